// File: rtl/add_n_bit_signed_serial_pkg.sv
// Shared ALU package for the bit-serial signed adder.
// Contents:
//   IDLE/RUN/DONE   state encodings, also wrapped in the state_e enum
//   clog2           ceiling log2, never less than 1, used to size the bit counter
package add_n_bit_signed_serial_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

  // Ceiling log2. The result is at least 1, so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < value) begin
      w++;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/add_n_bit_signed_serial_fa.sv
// Single-bit full adder: the one arithmetic slice the serial adder reuses on every bit.
// Ports:
//   a, b   addend bits
//   cin    carry in
//   s      sum bit
//   cout   carry out (majority of a, b, cin)
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_n_bit_signed_serial.sv
// Bit-serial signed adder: result = a + b at full precision (n+1 bits, cannot overflow).
// One full-adder slice works through the sign-extended operands LSB first, one bit per edge.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   enable   unit enable; low freezes RUN and makes IDLE ignore start
//   start    job request, accepted in IDLE when enable is high
//   a, b     signed n-bit operands, captured on the accepting edge
//   busy     high in RUN and DONE
//   valid    one-cycle pulse while result holds a new sum
//   result   signed n+1-bit sum, held until the next job finishes
module add_n_bit_signed_serial
  import add_n_bit_signed_serial_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                start,
  input  logic signed [n-1:0] a,
  input  logic signed [n-1:0] b,
  output logic                busy,
  output logic                valid,
  output logic signed [n:0]   result
);

  localparam int unsigned CntW = clog2(n + 1);

  state_e          state_q, state_d;
  logic [n:0]      op_a_q, op_a_d;
  logic [n:0]      op_b_q, op_b_d;
  logic [n:0]      sum_q, sum_d;
  logic [n:0]      result_q, result_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] count_q, count_d;

  logic fa_s;
  logic fa_cout;

  full_adder_1bit u_fa (
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sum_d    = sum_q;
    result_d = result_q;
    carry_d  = carry_q;
    count_d  = count_q;

    unique case (state_q)
      StIdle: begin
        if (start && enable) begin
          state_d = StRun;
          // Sign extension to n+1 bits is what makes the sum exact.
          op_a_d  = {a[n-1], a};
          op_b_d  = {b[n-1], b};
          carry_d = 1'b0;
          count_d = '0;
        end
      end
      StRun: begin
        if (enable) begin
          carry_d = fa_cout;
          op_a_d  = op_a_q >> 1;
          op_b_d  = op_b_q >> 1;
          // Sum bits enter at the MSB, so after n+1 shifts bit 0 sits at the LSB.
          sum_d   = {fa_s, sum_q[n:1]};
          count_d = count_q + 1'b1;
          if (count_q == CntW'(n)) begin
            state_d  = StDone;
            result_d = {fa_s, sum_q[n:1]};
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sum_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign valid  = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_add_n_bit_signed_serial.sv
module tb_add_n_bit_signed_serial;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              start;
  logic signed [3:0] a;
  logic signed [3:0] b;
  logic              busy;
  logic              valid;
  logic        [4:0] result;

  int checks;
  int fails;
  logic [4:0] last_result;

  add_n_bit_signed_serial #(
    .n (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a job and returns the number of edges from acceptance to valid (-1 on timeout).
  // Returns in the DONE cycle.
  task automatic run_job(input logic signed [3:0] x, input logic signed [3:0] y, output int lat);
    a = x;
    b = y;
    enable = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (result !== 5'b00000) begin fails++; $display("FAIL reset_result: got %b want 00000", result); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat;
    run_job(4'sd3, 4'sd2, lat);
    checks++; if (lat !== 5) begin fails++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++; if (result !== 5'b00101) begin fails++; $display("FAIL basic_result: got %b want 00101", result); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_done: got %b want 1", busy); end
    tick();
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL basic_valid_pulse: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    last_result = 5'b00101;
  endtask

  task automatic test_idle_gating();
    enable = 1'b0;
    start = 1'b1;
    a = 4'sd1;
    b = 4'sd1;
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL gated_start: got busy %b want 0", busy); end
    start = 1'b0;
    enable = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL gated_no_queue: got busy %b want 0", busy); end
  endtask

  task automatic test_extremes();
    int lat;
    run_job(-4'sd8, -4'sd8, lat);
    checks++; if (result !== 5'b10000 || lat !== 5) begin fails++; $display("FAIL ext_m8_m8: got %b lat %0d want 10000 lat 5", result, lat); end
    tick();
    run_job(4'sd7, 4'sd7, lat);
    checks++; if (result !== 5'b01110 || lat !== 5) begin fails++; $display("FAIL ext_7_7: got %b lat %0d want 01110 lat 5", result, lat); end
    tick();
    run_job(-4'sd8, 4'sd7, lat);
    checks++; if (result !== 5'b11111 || lat !== 5) begin fails++; $display("FAIL ext_m8_7: got %b lat %0d want 11111 lat 5", result, lat); end
    tick();
    last_result = 5'b11111;
  endtask

  task automatic test_pause();
    int   edges;
    logic stable_ok;
    logic seen;
    stable_ok = 1'b1;
    seen = 1'b0;
    a = -4'sd3;
    b = 4'sd5;
    enable = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    tick(); edges++;
    tick(); edges++;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); edges++;
      if (result !== last_result || busy !== 1'b1) stable_ok = 1'b0;
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); edges++;
      if (valid) begin
        seen = 1'b1;
        break;
      end
      if (result !== last_result) stable_ok = 1'b0;
    end
    checks++; if (stable_ok !== 1'b1) begin fails++; $display("FAIL pause_hold: result/busy not held, got %b want %b", result, last_result); end
    checks++; if (!seen || edges != 8) begin fails++; $display("FAIL pause_latency: got %0d edges (seen %b) want 8", edges, seen); end
    checks++; if (result !== 5'b00010) begin fails++; $display("FAIL pause_result: got %b want 00010", result); end
    tick();
    last_result = 5'b00010;
  endtask

  task automatic test_busy_start();
    int edges;
    int extra;
    logic seen;
    seen = 1'b0;
    a = 4'sd2;
    b = -4'sd5;
    enable = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    tick(); edges++;
    tick(); edges++;
    a = 4'sd1;
    b = 4'sd1;
    start = 1'b1;
    tick(); edges++;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); edges++;
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen || edges != 5) begin fails++; $display("FAIL busy_start_latency: got %0d edges (seen %b) want 5", edges, seen); end
    checks++; if (result !== 5'b11101) begin fails++; $display("FAIL busy_start_result: got %b want 11101", result); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid) extra++;
    end
    checks++; if (extra != 0) begin fails++; $display("FAIL busy_start_second_valid: got %0d pulses want 0", extra); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_start_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_hold_start();
    int edges;
    logic seen;
    seen = 1'b0;
    a = 4'sd1;
    b = 4'sd2;
    enable = 1'b1;
    start = 1'b1;
    tick();
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); edges++;
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen || edges != 5 || result !== 5'b00011) begin fails++; $display("FAIL hold_first: got %b edges %0d want 00011 edges 5", result, edges); end
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_idle_gap: got busy %b want 0", busy); end
    tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_reaccept: got busy %b want 1", busy); end
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen || result !== 5'b00011) begin fails++; $display("FAIL hold_second: got %b seen %b want 00011", result, seen); end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    a = 4'sd3;
    b = 4'sd3;
    enable = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || result !== 5'b00000) begin fails++; $display("FAIL reset_mid_clear: got busy %b valid %b result %b want 0 0 00000", busy, valid, result); end
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid || busy) pulses++;
    end
    checks++; if (pulses != 0) begin fails++; $display("FAIL reset_mid_no_valid: got %0d active cycles want 0", pulses); end
    run_job(-4'sd1, -4'sd1, lat);
    checks++; if (result !== 5'b11110 || lat !== 5) begin fails++; $display("FAIL reset_mid_next: got %b lat %0d want 11110 lat 5", result, lat); end
    tick();
  endtask

  task automatic test_async_reset();
    int lat;
    run_job(4'sd7, -4'sd2, lat);
    tick();
    checks++; if (result !== 5'b00101) begin fails++; $display("FAIL async_setup: got %b want 00101", result); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (result !== 5'b00000 || busy !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL async_reset: got result %b busy %b valid %b want 00000 0 0", result, busy, valid); end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    int lat;
    logic [4:0] expv;
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        expv = 5'(i + j);
        run_job(4'(i), 4'(j), lat);
        checks++;
        if (result !== expv || lat !== 5) begin
          fails++;
          $display("FAIL sweep %0d+%0d: got %b lat %0d want %b lat 5", i, j, result, lat, expv);
        end
        tick();
      end
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    last_result = 5'b00000;
    test_reset();
    test_basic();
    test_idle_gating();
    test_extremes();
    test_pause();
    test_busy_start();
    test_hold_start();
    test_reset_mid();
    test_async_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
